// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  // Byte count of an access; the illegal encoding yields zero.
  function automatic logic [2:0] size_bytes(logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Lanes touched across a lo/hi word pair: bits [3:0] lo word, [7:4] hi word.
  function automatic logic [7:0] byte_mask(logic [1:0] off, logic [2:0] nbytes);
    logic [7:0] m;
    m = (8'd1 << nbytes) - 8'd1;
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Core-side request/response and dataMemory signals of the alignment unit.
interface lsu_align_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            stall;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            misalign_err;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  // Environment side: drives requests and returns memory read data.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  stall, rsp_valid, rsp_rdata, misalign_err, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output stall, rsp_valid, rsp_rdata, misalign_err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// Byte-lane datapath: store-side read-modify-write merge and load-side extract/extend.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  nbytes,
  input  logic        hi_word,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  input  logic        ld_unsigned,
  output logic [31:0] wd_merged,
  output logic [31:0] ld_data
);

  logic [63:0] spread;
  logic [7:0]  mask;
  logic [31:0] sel_data;
  logic [3:0]  sel_mask;
  logic [31:0] joined;

  always_comb begin
    // Store data laid across the lo/hi word pair; hi_word picks which half lands now.
    spread    = {32'b0, wdata} << (BYTE_W * off);
    mask      = byte_mask(off, nbytes);
    sel_data  = hi_word ? spread[63:32] : spread[31:0];
    sel_mask  = hi_word ? mask[7:4] : mask[3:0];
    wd_merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (sel_mask[k]) wd_merged[BYTE_W*k +: BYTE_W] = sel_data[BYTE_W*k +: BYTE_W];
    end

    joined = 32'({ld_hi, ld_lo} >> (BYTE_W * off));
    case (nbytes)
      3'd1:    ld_data = {{24{!ld_unsigned && joined[7]}}, joined[7:0]};
      3'd2:    ld_data = {{16{!ld_unsigned && joined[15]}}, joined[15:0]};
      default: ld_data = joined;
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit; spanning accesses split over two cycles, or fault
// when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  lsu_align_unit_if.slave bus
);

  state_e          state_q, state_d;
  logic [23:0]     lo_buf_q, lo_buf_d;
  logic [23:0]     lo_capture;
  logic [1:0]      off;
  logic [2:0]      nbytes;
  logic            active;
  logic            spanning;
  logic            in_second;
  logic [XLEN-1:0] lo_addr;
  logic [XLEN-1:0] hi_addr;
  logic [31:0]     ld_lo;
  logic [31:0]     ld_hi;
  logic [31:0]     wd_merged;
  logic [31:0]     ld_data;

  assign off       = bus.req_addr[1:0];
  assign nbytes    = size_bytes(bus.req_size);
  assign active    = bus.req_valid && (bus.req_size != 2'b11);
  assign spanning  = active && ((3'(off) + nbytes) > 3'd4);
  assign lo_addr   = {bus.req_addr[XLEN-1:2], 2'b00};
  assign hi_addr   = lo_addr + XLEN'(4);
  assign in_second = (state_q == SECOND);
  // Byte 0 of the lo word is never part of a spanning access, so lo_buf holds bytes 3..1.
  assign ld_lo     = in_second ? {lo_buf_q, 8'h00} : bus.mem_rd;
  assign ld_hi     = in_second ? bus.mem_rd : '0;

  always_comb begin
    lo_capture = '0;
    for (int k = 1; k < 4; k++) begin
      if (k >= int'(off)) lo_capture[BYTE_W*(k-1) +: BYTE_W] = bus.mem_rd[BYTE_W*k +: BYTE_W];
    end
  end

  lsu_lane_merge u_lane_merge (
    .old_word   (bus.mem_rd),
    .wdata      (bus.req_wdata),
    .off        (off),
    .nbytes     (nbytes),
    .hi_word    (in_second),
    .ld_lo      (ld_lo),
    .ld_hi      (ld_hi),
    .ld_unsigned(bus.req_unsigned),
    .wd_merged  (wd_merged),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_buf_q <= lo_buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_buf_d = lo_buf_q;
    unique case (state_q)
      IDLE: begin
`ifndef LSU_MISALIGN_TRAP_EN
        if (spanning) begin
          state_d = SECOND;
          if (!bus.req_we) lo_buf_d = lo_capture;
        end
`endif
      end
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall        = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = '0;
    bus.misalign_err = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wd       = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          bus.mem_addr = lo_addr;
          if (spanning) begin
`ifdef LSU_MISALIGN_TRAP_EN
            bus.misalign_err = 1'b1;
`else
            bus.stall = 1'b1;
            if (bus.req_we) begin
              bus.mem_we = 1'b1;
              bus.mem_wd = wd_merged;
            end
`endif
          end else if (active) begin
            if (bus.req_we) begin
              bus.mem_we = 1'b1;
              bus.mem_wd = wd_merged;
            end else begin
              bus.rsp_valid = 1'b1;
              bus.rsp_rdata = ld_data;
            end
          end
        end
        SECOND: begin
          bus.mem_addr = hi_addr;
          if (active) begin
            if (bus.req_we) begin
              bus.mem_we = 1'b1;
              bus.mem_wd = wd_merged;
            end else begin
              bus.rsp_valid = 1'b1;
              bus.rsp_rdata = ld_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit with a word-addressed memory model.
module tb_lsu_align_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_align_unit_if #(.XLEN(32)) bus ();

  lsu_align_unit #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [8];
  assign bus.mem_rd = mem[bus.mem_addr[4:2]];

  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'h44332211;
      mem[1] <= 32'h88776655;
      mem[2] <= 32'hDDCCBBAA;
      for (int i = 3; i < 8; i++) mem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[4:2]] <= bus.mem_wd;
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got %h expected none", bus.rsp_rdata);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, mon_exp);
        end
      end else begin
        chk("rdata_zero_when_not_valid", bus.rsp_rdata, 32'h0);
      end
    end
  end

  task automatic access(input string name, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit span);
    int stalls;
    bit trap;
    trap = TRAP && span;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    if (!we && !trap && size != 2'b11) exp_q.push_back(exp_rd);
    stalls = 0;
    @(negedge clk);
    while (bus.stall && stalls < 4) begin
      stalls++;
      @(negedge clk);
    end
    chk({name, "/stall_cycles"}, 32'(stalls), (span && !TRAP) ? 32'd1 : 32'd0);
    chk({name, "/misalign_err"}, 32'(bus.misalign_err), 32'(trap));
    chk({name, "/mem_we"}, 32'(bus.mem_we), 32'(we && !trap && size != 2'b11));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  initial begin
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h1;
    bus.req_wdata    = 32'h0;

    // Outputs held quiet during reset even with a spanning request presented.
    repeat (2) @(negedge clk);
    chk("rst/stall", 32'(bus.stall), 32'h0);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst/mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst/misalign_err", 32'(bus.misalign_err), 32'h0);
    chk("rst/mem_addr", bus.mem_addr, 32'h0);
    chk("rst/rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;

    // Loads on the preloaded image.
    access("lb_2", 0, 2'b00, 0, 32'h2, 32'h0, 32'h00000033, 0);
    access("lb_7", 0, 2'b00, 0, 32'h7, 32'h0, 32'hFFFFFF88, 0);
    access("lbu_7", 0, 2'b00, 1, 32'h7, 32'h0, 32'h00000088, 0);
    access("lb_0", 0, 2'b00, 0, 32'h0, 32'h0, 32'h00000011, 0);
    access("lh_0", 0, 2'b01, 0, 32'h0, 32'h0, 32'h00002211, 0);
    access("lh_1", 0, 2'b01, 0, 32'h1, 32'h0, 32'h00003322, 0);
    access("lh_6", 0, 2'b01, 0, 32'h6, 32'h0, 32'hFFFF8877, 0);
    access("lhu_6", 0, 2'b01, 1, 32'h6, 32'h0, 32'h00008877, 0);
    access("lhu_3", 0, 2'b01, 1, 32'h3, 32'h0, 32'h00005544, 1);
    access("lw_0", 0, 2'b10, 0, 32'h0, 32'h0, 32'h44332211, 0);
    access("lw_1", 0, 2'b10, 0, 32'h1, 32'h0, 32'h55443322, 1);
    access("lw_3", 0, 2'b10, 0, 32'h3, 32'h0, 32'h77665544, 1);
    access("lw_6", 0, 2'b10, 0, 32'h6, 32'h0, 32'hBBAA8877, 1);

    // Stores and read-back.
    access("sb_5", 1, 2'b00, 0, 32'h5, 32'h000000AA, 32'h0, 0);
    idle();
    chk("sb_5/word0", mem[0], 32'h44332211);
    chk("sb_5/word1", mem[1], 32'h8877AA55);
    access("sh_3", 1, 2'b01, 0, 32'h3, 32'h1234BEEF, 32'h0, 1);
    idle();
    chk("sh_3/word0", mem[0], TRAP ? 32'h44332211 : 32'hEF332211);
    chk("sh_3/word1", mem[1], TRAP ? 32'h8877AA55 : 32'h8877AABE);
    access("sw_2", 1, 2'b10, 0, 32'h2, 32'hCAFEF00D, 32'h0, 1);
    idle();
    chk("sw_2/word0", mem[0], TRAP ? 32'h44332211 : 32'hF00D2211);
    chk("sw_2/word1", mem[1], TRAP ? 32'h8877AA55 : 32'h8877CAFE);
    access("lw_2_back", 0, 2'b10, 0, 32'h2, 32'h0, 32'hCAFEF00D, 1);
    access("sw_8", 1, 2'b10, 0, 32'h8, 32'h01020304, 32'h0, 0);
    access("lw_8", 0, 2'b10, 0, 32'h8, 32'h0, 32'h01020304, 0);
    access("lh_a", 0, 2'b01, 0, 32'hA, 32'h0, 32'h00000102, 0);

    // Illegal size and idle store must not write.
    access("illegal_sz", 1, 2'b11, 0, 32'h4, 32'hFFFFFFFF, 32'h0, 0);
    idle();
    chk("illegal_sz/word1", mem[1], TRAP ? 32'h8877AA55 : 32'h8877CAFE);
    bus.req_we = 1'b1;
    @(negedge clk);
    chk("idle_store/mem_we", 32'(bus.mem_we), 32'h0);

    // Reset during SECOND aborts the split load.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h2;
    @(negedge clk);
    chk("abort/first_stall", 32'(bus.stall), 32'(!TRAP));
    chk("abort/misalign_err", 32'(bus.misalign_err), 32'(TRAP));
    chk("abort/first_mem_we", 32'(bus.mem_we), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort/rst_stall", 32'(bus.stall), 32'h0);
    chk("abort/rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort/idle_stall", 32'(bus.stall), 32'h0);
    access("abort/lb_0", 0, 2'b00, 0, 32'h0, 32'h0, 32'h00000011, 0);
    idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store alignment unit between the core's execute stage and dataMemory (word-addressed, combinational read, synchronous write, no byte enables).
- Converts byte, halfword and word requests at any byte address into whole-word memory accesses.
- Sub-word stores are done as a same-cycle read-modify-write; loads are sign- or zero-extended.
- Accesses that span two memory words are split over two cycles by a small FSM, which stalls the core for one cycle.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  core access request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as no-op
- req_unsigned  input  1  zero-extend loads (lbu/lhu)
- req_addr  input  XLEN  byte address
- req_wdata  input  XLEN  store data, right-justified
- stall  output  1  core must hold the request stable and not advance PC
- rsp_valid  output  1  load data valid this cycle
- rsp_rdata  output  XLEN  extended load data
- misalign_err  output  1  spanning-access fault pulse (see Optional Feature)
- mem_we  output  1  to dataMemory we
- mem_addr  output  XLEN  word-aligned byte address (low 2 bits = 0)
- mem_wd  output  XLEN  to dataMemory wd
- mem_rd  input  XLEN  from dataMemory rd

Behaviour:
- Clock, reset and byte order
  - Single clock clk. Reset rst is synchronous, active-high.
  - Little-endian: byte k of a word is bits [8k+7:8k].
  - off = req_addr[1:0]; lo_addr = {req_addr[31:2], 2'b00}; hi_addr = lo_addr + 4, wrapping modulo 2^32.
- Access classification
  - Non-spanning: byte (any off); half with off ≤ 2; word with off = 0.
  - Spanning: half with off = 3; word with off ≠ 0.
- FSM states: IDLE, SECOND. The state register plus a 24-bit lo_buf are the only flops.
- IDLE, non-spanning access
  - mem_addr = lo_addr.
  - Load: rsp_rdata = the extracted bytes, extended. rsp_valid = 1 combinationally in the same cycle. stall = 0.
  - Store: mem_wd = mem_rd with the target bytes replaced by req_wdata's low bytes. mem_we = 1. stall = 0.
- IDLE, spanning access
  - stall = 1; mem_addr = lo_addr.
  - Load: capture the upper (4 − off) bytes of mem_rd into lo_buf. rsp_valid = 0.
  - Store: RMW the upper (4 − off) bytes of the lo word, mem_we = 1.
  - Next state: SECOND.
- SECOND
  - mem_addr = hi_addr; stall = 0.
  - Load: assemble lo_buf (low bytes) with the low bytes of mem_rd, extend, rsp_valid = 1.
  - Store: RMW the low remaining bytes of the hi word, mem_we = 1.
  - Next state: IDLE.
- req_valid = 0 or req_size = 11: mem_we = 0, rsp_valid = 0, stall = 0, state unchanged if IDLE.
- Latency: non-spanning accesses take 0 extra cycles; spanning accesses take exactly 1 extra cycle.
- Reset
  - While rst = 1: state = IDLE, lo_buf = 0, and stall, rsp_valid, mem_we, misalign_err = 0.
  - rsp_rdata = 0 and mem_addr = 0 during reset.
  - Reset asserted in SECOND aborts the access. A split store may leave only the lo word written; this is accepted.
- When not rsp_valid, rsp_rdata = 0.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Spanning accesses are not split.
  - misalign_err = 1 for that single cycle; mem_we = 0; rsp_valid = 0; stall = 0.
  - The SECOND state is never entered.
- Undefined: the split behaviour above applies, and misalign_err is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - the size_e enum (SZ_B, SZ_H, SZ_W)
  - the state_e enum (IDLE, SECOND)
  - a byte-lane mask function and the BYTE_W = 8 constant
- Sub-module lsu_lane_merge (combinational) provides:
  - store-side byte-lane merge (old word, new data, offset, byte count)
  - load-side extract/extend
- The top level holds the FSM and lo_buf.

Test Plan (memory preloaded: word0 = 0x44332211, word1 = 0x88776655):
- lb at 0x2, signed -> rsp_valid in the same cycle, rsp_rdata = 0x00000033, stall = 0.
- lb at 0x7, signed -> 0xFFFFFF88; lbu at 0x7 -> 0x00000088.
- lw at 0x1 -> stall = 1 for one cycle; then rsp_rdata = 0x55443322 with rsp_valid = 1 on cycle 2.
- sh 0xBEEF at 0x3 -> two writes; word0 = 0xEF332211, word1 = 0x887766BE, stall high for 1 cycle.
- sb 0xAA at 0x5 -> single cycle, word1 = 0x8877AA55, word0 unchanged.
- lw at 0x2 with rst asserted during SECOND -> no rsp_valid, stall = 0, state IDLE. With LSU_MISALIGN_TRAP_EN defined: misalign_err = 1 for one cycle, memory unchanged.
